// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - dual-pipe writeback staging with even-wins collision stall
// Optional macro WB_STALL_CNT_EN adds the saturating stall_cnt output.
module wb_pipe #(
    parameter int MAX_LAT = 7,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_value_i,
    input  logic [2:0]        in_lat_i,
    output logic              ready_o,
    output logic              lat_err_o,
    output logic              head_valid_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_value_o
);
    // Index k holds slot k+1; index 0 is the head.
    logic [MAX_LAT-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q  [MAX_LAT];
    logic [ADDR_W-1:0]  addr_d  [MAX_LAT];
    logic [DATA_W-1:0]  value_q [MAX_LAT];
    logic [DATA_W-1:0]  value_d [MAX_LAT];
    logic               lat_ok, slot_busy, accept;

    assign lat_ok = (in_lat_i != 3'd0) && (int'(in_lat_i) <= MAX_LAT);

    // Slot L+1 must be empty so that slot L is free once the pipe shifts.
    always_comb begin
        slot_busy = 1'b0;
        for (int k = 1; k < MAX_LAT; k++) begin
            if (int'(in_lat_i) == k && valid_q[k]) slot_busy = 1'b1;
        end
    end

    assign ready_o   = reset | (!hold_i & (!lat_ok | !slot_busy));
    assign lat_err_o = !reset & !hold_i & in_valid_i & !lat_ok;
    assign accept    = !reset & !hold_i & in_valid_i & lat_ok & !slot_busy;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        value_d = value_q;
        if (!hold_i) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                if (k < MAX_LAT - 1) begin
                    valid_d[k] = valid_q[k+1];
                    addr_d[k]  = addr_q[k+1];
                    value_d[k] = value_q[k+1];
                end else begin
                    valid_d[k] = 1'b0;
                    addr_d[k]  = '0;
                    value_d[k] = '0;
                end
                if (accept && int'(in_lat_i) == k + 1) begin
                    valid_d[k] = 1'b1;
                    addr_d[k]  = in_addr_i;
                    value_d[k] = in_value_i;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
        addr_q  <= addr_d;
        value_q <= value_d;
    end

    assign head_valid_o = valid_q[0];
    assign head_addr_o  = valid_q[0] ? addr_q[0]  : '0;
    assign head_value_o = valid_q[0] ? value_q[0] : '0;
endmodule

module writeback_unit #(
    parameter int MAX_LAT = 7,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ep_valid,
    input  logic [ADDR_W-1:0] ep_rt_addr,
    input  logic [DATA_W-1:0] ep_value,
    input  logic [2:0]        ep_lat,
    output logic              ep_ready,
    input  logic              op_valid,
    input  logic [ADDR_W-1:0] op_rt_addr,
    input  logic [DATA_W-1:0] op_value,
    input  logic [2:0]        op_lat,
    output logic              op_ready,
    output logic [ADDR_W-1:0] rt_ep_address,
    output logic [DATA_W-1:0] rt_value_ep,
    output logic              wrt_en_ep,
    output logic [ADDR_W-1:0] rt_op_address,
    output logic [DATA_W-1:0] rt_value_op,
    output logic              wrt_en_op,
    output logic              stall_odd,
`ifdef WB_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              lat_err
);
    logic              ep_hv, op_hv, ep_err, op_err;
    logic [ADDR_W-1:0] ep_ha, op_ha;
    logic [DATA_W-1:0] ep_hd, op_hd;

    wb_pipe #(.MAX_LAT(MAX_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_even (
        .clock(clock), .reset(reset), .hold_i(1'b0),
        .in_valid_i(ep_valid), .in_addr_i(ep_rt_addr), .in_value_i(ep_value), .in_lat_i(ep_lat),
        .ready_o(ep_ready), .lat_err_o(ep_err),
        .head_valid_o(ep_hv), .head_addr_o(ep_ha), .head_value_o(ep_hd)
    );

    wb_pipe #(.MAX_LAT(MAX_LAT), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_odd (
        .clock(clock), .reset(reset), .hold_i(stall_odd),
        .in_valid_i(op_valid), .in_addr_i(op_rt_addr), .in_value_i(op_value), .in_lat_i(op_lat),
        .ready_o(op_ready), .lat_err_o(op_err),
        .head_valid_o(op_hv), .head_addr_o(op_ha), .head_value_o(op_hd)
    );

    // Even pipe always wins a same-register collision; odd head waits in place.
    assign stall_odd     = !reset & ep_hv & op_hv & (ep_ha == op_ha);
    assign wrt_en_ep     = !reset & ep_hv;
    assign rt_ep_address = wrt_en_ep ? ep_ha : '0;
    assign rt_value_ep   = wrt_en_ep ? ep_hd : '0;
    assign wrt_en_op     = !reset & op_hv & !stall_odd;
    assign rt_op_address = wrt_en_op ? op_ha : '0;
    assign rt_value_op   = wrt_en_op ? op_hd : '0;
    assign lat_err       = ep_err | op_err;

`ifdef WB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_odd && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
    always_ff @(posedge clock) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed and random checks of writeback_unit against a due-cycle model
module tb_writeback_unit;
    localparam int MAX_LAT = 7;

    logic         clock = 1'b0;
    logic         reset;
    logic         ep_valid, op_valid;
    logic [6:0]   ep_rt_addr, op_rt_addr;
    logic [127:0] ep_value, op_value;
    logic [2:0]   ep_lat, op_lat;
    logic         ep_ready, op_ready;
    logic [6:0]   rt_ep_address, rt_op_address;
    logic [127:0] rt_value_ep, rt_value_op;
    logic         wrt_en_ep, wrt_en_op, stall_odd, lat_err;
`ifdef WB_STALL_CNT_EN
    logic [15:0]  stall_cnt;
    int           stall_exp = 0;
`endif

    always #5 clock = ~clock;

    writeback_unit dut (
        .clock(clock), .reset(reset),
        .ep_valid(ep_valid), .ep_rt_addr(ep_rt_addr), .ep_value(ep_value), .ep_lat(ep_lat), .ep_ready(ep_ready),
        .op_valid(op_valid), .op_rt_addr(op_rt_addr), .op_value(op_value), .op_lat(op_lat), .op_ready(op_ready),
        .rt_ep_address(rt_ep_address), .rt_value_ep(rt_value_ep), .wrt_en_ep(wrt_en_ep),
        .rt_op_address(rt_op_address), .rt_value_op(rt_value_op), .wrt_en_op(wrt_en_op),
        .stall_odd(stall_odd),
`ifdef WB_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .lat_err(lat_err)
    );

    // Each staged result is remembered with the absolute cycle in which it must write.
    typedef struct {
        logic [6:0]   addr;
        logic [127:0] val;
        int           due;
    } ent_t;

    ent_t eq[$];
    ent_t oq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int find_due(input ent_t q[$], input int d);
        for (int i = 0; i < q.size(); i++) if (q[i].due == d) return i;
        return -1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step(input logic r,
                        input logic ev, input logic [6:0] ea, input logic [127:0] ed, input logic [2:0] el,
                        input logic ov, input logic [6:0] oa, input logic [127:0] od, input logic [2:0] ol);
        int   ei, oi;
        logic e_w, o_h, stl, o_w, e_ok, o_ok, e_rdy, o_rdy, e_acc, o_acc, err;
        ent_t ne;
        reset = r;
        ep_valid = ev; ep_rt_addr = ea; ep_value = ed; ep_lat = el;
        op_valid = ov; op_rt_addr = oa; op_value = od; op_lat = ol;
        @(negedge clock);
        ei    = find_due(eq, cyc);
        oi    = find_due(oq, cyc);
        e_w   = !r && ei >= 0;
        o_h   = !r && oi >= 0;
        stl   = e_w && o_h && (eq[ei].addr == oq[oi].addr);
        o_w   = o_h && !stl;
        e_ok  = el != 3'd0 && int'(el) <= MAX_LAT;
        o_ok  = ol != 3'd0 && int'(ol) <= MAX_LAT;
        e_rdy = r || !e_ok || int'(el) == MAX_LAT || find_due(eq, cyc + int'(el)) < 0;
        o_rdy = r || (!stl && (!o_ok || int'(ol) == MAX_LAT || find_due(oq, cyc + int'(ol)) < 0));
        err   = !r && ((ev && !e_ok) || (!stl && ov && !o_ok));
        e_acc = !r && ev && e_ok && e_rdy;
        o_acc = !r && ov && o_ok && o_rdy;

        chk("wrt_en_ep", 128'(wrt_en_ep), 128'(e_w));
        chk("rt_ep_address", 128'(rt_ep_address), e_w ? 128'(eq[ei].addr) : 128'(0));
        chk("rt_value_ep", rt_value_ep, e_w ? eq[ei].val : 128'(0));
        chk("wrt_en_op", 128'(wrt_en_op), 128'(o_w));
        chk("rt_op_address", 128'(rt_op_address), o_w ? 128'(oq[oi].addr) : 128'(0));
        chk("rt_value_op", rt_value_op, o_w ? oq[oi].val : 128'(0));
        chk("stall_odd", 128'(stall_odd), 128'(stl));
        chk("ep_ready", 128'(ep_ready), 128'(e_rdy));
        chk("op_ready", 128'(op_ready), 128'(o_rdy));
        chk("lat_err", 128'(lat_err), 128'(err));
`ifdef WB_STALL_CNT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(stall_exp));
        if (r) stall_exp = 0;
        else if (stl && stall_exp < 65535) stall_exp++;
`endif

        if (r) begin
            eq.delete();
            oq.delete();
        end else begin
            if (e_w) eq.delete(ei);
            if (stl) begin
                foreach (oq[i]) oq[i].due++;
            end else if (o_w) begin
                oq.delete(oi);
            end
            if (e_acc) begin
                ne.addr = ea; ne.val = ed; ne.due = cyc + int'(el);
                eq.push_back(ne);
            end
            if (o_acc) begin
                ne.addr = oa; ne.val = od; ne.due = cyc + int'(ol);
                oq.push_back(ne);
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 128'd0, 3'd1, 1'b0, 7'd0, 128'd0, 3'd1);
    endtask

    initial begin
        reset = 1'b1;
        ep_valid = 1'b0; ep_rt_addr = '0; ep_value = '0; ep_lat = 3'd1;
        op_valid = 1'b0; op_rt_addr = '0; op_value = '0; op_lat = 3'd1;
        @(posedge clock);
        #1;
        step(1'b1, 1'b0, 7'd0, 128'd0, 3'd1, 1'b0, 7'd0, 128'd0, 3'd1);
        step(1'b1, 1'b1, 7'd4, 128'd7, 3'd1, 1'b1, 7'd4, 128'd8, 3'd1);
        idle(2);

        // Latency timing: write exactly lat cycles after acceptance.
        step(1'b0, 1'b1, 7'd5, {16{8'hAA}}, 3'd3, 1'b0, 7'd0, 128'd0, 3'd1);
        idle(5);

        // Dual write to different registers.
        step(1'b0, 1'b1, 7'd3, rnd128(), 3'd2, 1'b1, 7'd9, rnd128(), 3'd2);
        idle(4);

        // Same-register collision: even wins, odd follows one cycle later.
        step(1'b0, 1'b1, 7'd20, rnd128(), 3'd1, 1'b1, 7'd20, rnd128(), 3'd1);
        step(1'b0, 1'b0, 7'd0, 128'd0, 3'd1, 1'b1, 7'd21, rnd128(), 3'd1);
        idle(4);

        // Backpressure on the even pipe.
        step(1'b0, 1'b1, 7'd7, rnd128(), 3'd4, 1'b0, 7'd0, 128'd0, 3'd1);
        step(1'b0, 1'b1, 7'd8, 128'h1234, 3'd3, 1'b0, 7'd0, 128'd0, 3'd1);
        step(1'b0, 1'b1, 7'd8, 128'h1234, 3'd3, 1'b0, 7'd0, 128'd0, 3'd1);
        idle(6);

        // Illegal latency on each pipe, plus maximum latency.
        step(1'b0, 1'b1, 7'd11, rnd128(), 3'd0, 1'b0, 7'd0, 128'd0, 3'd1);
        step(1'b0, 1'b0, 7'd0, 128'd0, 3'd1, 1'b1, 7'd12, rnd128(), 3'd0);
        step(1'b0, 1'b1, 7'd13, rnd128(), 3'd7, 1'b1, 7'd14, rnd128(), 3'd7);
        idle(9);

        // Reset mid-flight discards staged results.
        step(1'b0, 1'b1, 7'd30, rnd128(), 3'd5, 1'b1, 7'd31, rnd128(), 3'd6);
        step(1'b0, 1'b1, 7'd32, rnd128(), 3'd5, 1'b0, 7'd0, 128'd0, 3'd1);
        step(1'b1, 1'b0, 7'd0, 128'd0, 3'd1, 1'b0, 7'd0, 128'd0, 3'd1);
        idle(9);

        // Random traffic over a few registers so collisions are frequent.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 2) != 0), 7'($urandom_range(0, 3)), rnd128(), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) != 0), 7'($urandom_range(0, 3)), rnd128(), 3'($urandom_range(0, 7)));
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
